// File: rtl/bus_keeper_decay.sv
// Bus keeper with leaking charge: holds the last driven value of each
// undriven bit and decays it to a pull value after a programmable idle time.
// Ports: clk, rst_n (async, active-low), drv_mask / bus_in (strong drivers),
//        bus_out (resolved read value), keep_oe (weak-drive enables),
//        stale (bit has decayed).
module bus_keeper_decay #(
  parameter int                 WIDTH        = 8,
  parameter int                 DECAY_CYCLES = 16,
  parameter logic [WIDTH-1:0]   DECAY_VALUE  = '1,
  parameter logic [WIDTH-1:0]   RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] drv_mask,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] keep_oe,
  output logic [WIDTH-1:0] stale
);

  localparam int CW = (DECAY_CYCLES < 1) ? 1 : $clog2(DECAY_CYCLES + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DECAY_CYCLES);

  typedef enum logic [1:0] {
    ST_DRIVEN  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DECAYED = 2'd2
  } st_e;

  st_e             st_q  [WIDTH];
  st_e             st_d  [WIDTH];
  logic [CW-1:0]   cnt_q [WIDTH];
  logic [CW-1:0]   cnt_d [WIDTH];
  logic [CW:0]     inc   [WIDTH];
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        st_q[i]  <= ST_HOLD;
        cnt_q[i] <= '0;
      end
      cap_q <= RESET_VALUE;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      cap_q <= cap_d;
    end
  end

  // Decayed bits keep cap untouched; only the read mux changes.
  always_comb begin
    cap_d = cap_q;
    for (int i = 0; i < WIDTH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      inc[i]   = {1'b0, cnt_q[i]} + (CW + 1)'(1);
      if (drv_mask[i]) begin
        cap_d[i] = bus_in[i];
        cnt_d[i] = '0;
        st_d[i]  = ST_DRIVEN;
      end else if (st_q[i] != ST_DECAYED) begin
        if (DECAY_CYCLES == 0) begin
          st_d[i] = ST_HOLD;
        end else if (inc[i] == LIMIT) begin
          cnt_d[i] = inc[i][CW-1:0];
          st_d[i]  = ST_DECAYED;
        end else begin
          cnt_d[i] = inc[i][CW-1:0];
          st_d[i]  = ST_HOLD;
        end
      end
    end
  end

  always_comb begin
    bus_out = '0;
    stale   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      stale[i] = (st_q[i] == ST_DECAYED);
      if (drv_mask[i])
        bus_out[i] = bus_in[i];
      else if (stale[i])
        bus_out[i] = DECAY_VALUE[i];
      else
        bus_out[i] = cap_q[i];
    end
  end

  assign keep_oe = ~drv_mask;

endmodule

// File: tb/tb_bus_keeper_decay.sv
// Self-checking bench for bus_keeper_decay: directed scenarios plus
// randomized traffic against an idle-count reference model.
module tb_bus_keeper_decay;

  localparam int          DC = 4;
  localparam logic [7:0]  DV = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] drv_mask, bus_in, bus_out, keep_oe, stale;
  logic [7:0] drv_mask0, bus_in0, bus_out0, keep_oe0, stale0;

  int errors = 0;
  int checks = 0;

  // Reference: per bit, count of consecutive undriven edges and last value.
  int         idle [8];
  logic [7:0] last;

  always #5 clk = ~clk;

  bus_keeper_decay #(
    .WIDTH(8), .DECAY_CYCLES(DC),
    .DECAY_VALUE(DV), .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .drv_mask(drv_mask), .bus_in(bus_in),
    .bus_out(bus_out), .keep_oe(keep_oe), .stale(stale)
  );

  bus_keeper_decay #(
    .WIDTH(8), .DECAY_CYCLES(0),
    .DECAY_VALUE(8'hFF), .RESET_VALUE(8'h00)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .drv_mask(drv_mask0), .bus_in(bus_in0),
    .bus_out(bus_out0), .keep_oe(keep_oe0), .stale(stale0)
  );

  task automatic model_reset();
    for (int i = 0; i < 8; i++) idle[i] = 0;
    last = 8'h00;
  endtask

  function automatic logic [7:0] exp_stale();
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = (idle[i] >= DC);
    return s;
  endfunction

  function automatic logic [7:0] exp_out();
    logic [7:0] s, o;
    s = exp_stale();
    for (int i = 0; i < 8; i++)
      o[i] = drv_mask[i] ? bus_in[i] : (s[i] ? DV[i] : last[i]);
    return o;
  endfunction

  // One rising edge; model samples the same inputs as the DUT.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      if (drv_mask[i]) begin
        last[i] = bus_in[i];
        idle[i] = 0;
      end else begin
        idle[i] = idle[i] + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv_mask = 8'h00; bus_in = 8'h00;
    drv_mask0 = 8'h00; bus_in0 = 8'h00;
    model_reset();
    #3;
    checks++;
    if (bus_out !== 8'h00 || stale !== 8'h00 || keep_oe !== 8'hFF) begin
      errors++;
      $display("FAIL reset_state: out=%h stale=%h oe=%h want 00/00/ff",
               bus_out, stale, keep_oe);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (e < 4 && (bus_out !== 8'h00 || stale !== 8'h00)) begin
        errors++;
        $display("FAIL reset_hold e%0d: out=%h stale=%h want 00/00",
                 e, bus_out, stale);
      end else if (e == 4 && (bus_out !== 8'hFF || stale !== 8'hFF)) begin
        errors++;
        $display("FAIL reset_decay: out=%h stale=%h want ff/ff",
                 bus_out, stale);
      end
    end
  endtask

  task automatic test_drive_release();
    drv_mask = 8'hFF; bus_in = 8'hA5;
    #1;
    checks++;
    if (bus_out !== 8'hA5 || keep_oe !== 8'h00) begin
      errors++;
      $display("FAIL drive_comb: out=%h oe=%h want a5/00", bus_out, keep_oe);
    end
    tick(); tick();
    drv_mask = 8'h00; bus_in = 8'h00;
    #1;
    checks++;
    if (keep_oe !== 8'hFF || bus_out !== 8'hA5) begin
      errors++;
      $display("FAIL release_comb: out=%h oe=%h want a5/ff", bus_out, keep_oe);
    end
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (e < 4 && (bus_out !== 8'hA5 || stale !== 8'h00)) begin
        errors++;
        $display("FAIL release_hold e%0d: out=%h stale=%h want a5/00",
                 e, bus_out, stale);
      end else if (e == 4 && (bus_out !== 8'hFF || stale !== 8'hFF)) begin
        errors++;
        $display("FAIL release_decay: out=%h stale=%h want ff/ff",
                 bus_out, stale);
      end
    end
  endtask

  task automatic test_partial();
    drv_mask = 8'hFF; bus_in = 8'hA5;
    tick();
    drv_mask = 8'h00;
    tick(); tick();
    drv_mask = 8'h0F; bus_in = 8'h3C;
    tick();
    drv_mask = 8'h00; bus_in = 8'h00;
    #1;
    checks++;
    if (bus_out !== 8'hAC) begin
      errors++;
      $display("FAIL partial_merge: out=%h want ac", bus_out);
    end
    tick(); tick();
    checks++;
    if (bus_out !== 8'hFC || stale !== 8'hF0) begin
      errors++;
      $display("FAIL partial_hi: out=%h stale=%h want fc/f0", bus_out, stale);
    end
    tick(); tick();
    checks++;
    if (bus_out !== 8'hFF || stale !== 8'hFF) begin
      errors++;
      $display("FAIL partial_lo: out=%h stale=%h want ff/ff", bus_out, stale);
    end
  endtask

  task automatic test_redrive();
    drv_mask = 8'hFF; bus_in = 8'h5A;
    tick();
    drv_mask = 8'h00;
    tick(); tick(); tick();
    drv_mask = 8'hFF;
    tick();
    drv_mask = 8'h00;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (e < 4 && (bus_out !== 8'h5A || stale !== 8'h00)) begin
        errors++;
        $display("FAIL redrive_hold e%0d: out=%h stale=%h want 5a/00",
                 e, bus_out, stale);
      end else if (e == 4 && (bus_out !== 8'hFF || stale !== 8'hFF)) begin
        errors++;
        $display("FAIL redrive_decay: out=%h stale=%h want ff/ff",
                 bus_out, stale);
      end
    end
  endtask

  task automatic test_async_reset();
    drv_mask = 8'hFF; bus_in = 8'h81;
    tick();
    drv_mask = 8'h00;
    tick(); tick();
    checks++;
    if (bus_out !== 8'h81) begin
      errors++;
      $display("FAIL pre_reset_hold: out=%h want 81", bus_out);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus_out !== 8'h00 || stale !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: out=%h stale=%h want 00/00",
               bus_out, stale);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus_out !== 8'h00 || stale !== 8'h00) begin
      errors++;
      $display("FAIL post_reset: out=%h stale=%h want 00/00", bus_out, stale);
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int n = 0; n < 300; n++) begin
      drv_mask = 8'($urandom & $urandom & $urandom);
      bus_in   = 8'($urandom);
      #1;
      e = exp_out();
      checks++;
      if (bus_out !== e || keep_oe !== ~drv_mask) begin
        errors++;
        $display("FAIL rand_comb n%0d: out=%h oe=%h want %h/%h",
                 n, bus_out, keep_oe, e, ~drv_mask);
      end
      tick();
      e = exp_out();
      checks++;
      if (bus_out !== e || stale !== exp_stale()) begin
        errors++;
        $display("FAIL rand_edge n%0d: out=%h stale=%h want %h/%h",
                 n, bus_out, stale, e, exp_stale());
      end
    end
  endtask

  task automatic test_no_decay();
    drv_mask0 = 8'hFF; bus_in0 = 8'hC3;
    tick();
    drv_mask0 = 8'h00; bus_in0 = 8'h00;
    for (int n = 0; n < 1000; n++) begin
      tick();
      checks++;
      if (bus_out0 !== 8'hC3 || stale0 !== 8'h00 || keep_oe0 !== 8'hFF) begin
        errors++;
        $display("FAIL no_decay n%0d: out=%h stale=%h oe=%h want c3/00/ff",
                 n, bus_out0, stale0, keep_oe0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_drive_release();
    test_partial();
    test_redrive();
    test_async_reset();
    test_random();
    test_no_decay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
